control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for dataPath. A Moore FSM drives the datapath strobes through fetch (T0-T2) and execute (T3-T7).
//  Supported instructions: ld, ldi, st, add, sub, and, or, addi, halt. Unknown opcodes execute as a nop.
//  Replaces the hand-written per-state stimulus in the datapath benches. Sits beside dataPath and memory, and reads back IR.
// PARAMETERS
//  OP_LD    5'd0   opcode of ld Ra,C(Rb)
//  OP_LDI   5'd1   opcode of ldi Ra,C(Rb)
//  OP_ST    5'd2   opcode of st C(Rb),Ra
//  OP_ADD   5'd3   opcode of add Ra,Rb,Rc (OP_SUB=4, OP_AND=5, OP_OR=6)
//  OP_ADDI  5'd12  opcode of addi Ra,Rb,C
//  OP_HALT  5'd27  opcode of halt
//  ALU_ADD  4'd2   ALU code for add (ALU_SUB=4'd3, ALU_AND=4'd0, ALU_OR=4'd1)
// PORTS
//  clk        in   1   system clock; the FSM advances on negedge so strobes are stable at the datapath posedge
//  reset      in   1   synchronous, active-low reset (sampled on negedge clk)
//  run        in   1   1 = fetch the next instruction; 0 = pause in T0
//  mem_ready  in   1   memory has completed the current read/write
//  IR         in   32  instruction register value (opcode IR[31:27])
//  PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin  out 1 each   datapath strobes
//  read, write                   out  1 each  memory strobes
//  mdr_read                      out  2       MDR source: 00 bus, 01 memory
//  control                       out  4       ALU operation code
//  Cout, BAout, Rin, Rout, GRA, GRB, GRC   out  1 each  register select/strobes
//  halted                        out  1       1 while in HALT
//  busy                          out  1       1 in every state except RST, T0-while-paused and HALT
// BEHAVIOUR
//  - Outputs are a pure function of the state register (Moore). Unlisted strobes are 0 in a state.
//  - control holds ALU_ADD unless a state explicitly sets it.
//  - reset==0 at a negedge forces state RST in that same edge, from any state, including a T1 or T6/T7 memory wait.
//    RST: all outputs 0, mdr_read=00, control=ALU_ADD.
//  - RST -> T0 on the first negedge with reset==1.
//  - T0: PCout MARin IncPc Zlowin. If run==0, stay in T0 with all outputs 0; otherwise go to T1.
//  - T1: Zlowout PCin on the first cycle only; read MDRin mdr_read=01 on every cycle.
//    Hold T1 while mem_ready==0. Go to T2 at the first negedge with mem_ready==1. PC is incremented exactly once.
//  - T2: MDRout IRin. Then T3. The opcode is sampled from IR at the T3 entry edge and held until the instruction ends.
//  - ldi/addi: T3 GRB BAout(ldi) or Rout(addi), Yin; T4 Cout Zlowin control=ALU_ADD; T5 Zlowout GRA Rin -> T0.
//  - add/sub/and/or: T3 GRB Rout Yin; T4 GRC Rout Zlowin, control=op ALU code; T5 Zlowout GRA Rin -> T0.
//  - ld: T3/T4 as ldi; T5 Zlowout MARin; T6 read MDRin mdr_read=01, hold until mem_ready; T7 MDRout GRA Rin -> T0.
//  - st: T3-T5 as ld; T6 GRA Rout MDRin mdr_read=00; T7 write, hold until mem_ready -> T0.
//  - halt: T3 -> HALT; remain in HALT (halted=1, all other outputs 0) until reset.
//  - Unknown opcode: T3 with all outputs 0 -> T0.
//  - Latency with mem_ready tied 1: ldi/addi/ALU = 6 cycles; ld/st = 8 cycles.
//  - A run deassert mid-instruction has no effect until the next T0.
//  - mem_ready is ignored outside T1/T6(ld)/T7(st).
// TESTING
//  1. reset=0 for 2 cycles in any state -> all outputs 0; reset=1 -> T0 at the next negedge, PCout=MARin=IncPc=1.
//  2. mem_ready=1, run=1, IR=32'h0880_0005 (ldi r1,5(r0)) -> T0..T5 in 6 cycles.
//     Check T5: Zlowout=GRA=Rin=1. With dataPath attached, R1Val=5.
//  3. IR=32'h1911_0000 (add r2,r2,r2): T4 must show GRC=Rout=Zlowin=1, control=2.
//     With OP_SUB, control=3. Back to T0 after 6 cycles.
//  4. ld with mem_ready=0 for 3 cycles in T1 and 2 cycles in T6 -> 13 cycles total.
//     PCin asserted exactly one cycle; Rin only in T7.
//  5. st -> T6 mdr_read=00 MDRin=1; T7 write=1 held until mem_ready. Assert reset=0 mid-T7 -> RST, write=0 on that edge.
//  6. IR opcode 27 -> halted=1 after T3 and stays 1 for 20 cycles. Opcode 31 -> nop, back to T0 after 4 cycles.
//     run=0 -> FSM stays in T0 with all strobes 0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for dataPath.
// Fetch runs through T0-T2 and execute through T3-T7. The state register
// moves on the falling clock edge so every strobe is settled before the
// datapath samples it on the rising edge.
// Ports:
//   clk, reset     clock; synchronous active-low reset, sampled on negedge
//   run            1 = fetch the next instruction, 0 = pause in T0
//   mem_ready      memory finished the current read/write
//   IR             instruction register, opcode in IR[31:27]
//   PCout..Zlowin  datapath strobes
//   read, write    memory strobes
//   mdr_read       MDR source select (00 bus, 01 memory)
//   control        ALU operation code
//   Cout..GRC      register select/strobes
//   halted, busy   status
module control_sequencer #(
  parameter logic [4:0] OP_LD   = 5'd0,
  parameter logic [4:0] OP_LDI  = 5'd1,
  parameter logic [4:0] OP_ST   = 5'd2,
  parameter logic [4:0] OP_ADD  = 5'd3,
  parameter logic [4:0] OP_SUB  = 5'd4,
  parameter logic [4:0] OP_AND  = 5'd5,
  parameter logic [4:0] OP_OR   = 5'd6,
  parameter logic [4:0] OP_ADDI = 5'd12,
  parameter logic [4:0] OP_HALT = 5'd27,
  parameter logic [3:0] ALU_ADD = 4'd2,
  parameter logic [3:0] ALU_SUB = 4'd3,
  parameter logic [3:0] ALU_AND = 4'd0,
  parameter logic [3:0] ALU_OR  = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPc,
  output logic        Zlowin,
  output logic        read,
  output logic        write,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control,
  output logic        Cout,
  output logic        BAout,
  output logic        Rin,
  output logic        Rout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        halted,
  output logic        busy
);

  // T1 is split into its first cycle and the memory-wait cycles so the PC
  // update strobes fire exactly once while the state stays a pure register.
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state, state_nx;
  logic [4:0] op;

  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  logic is_ld, is_st, is_ldi, is_addi, is_alu, is_halt, is_base, known;
  logic [3:0] alu_code;

  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_ldi  = (op == OP_LDI);
  assign is_addi = (op == OP_ADDI);
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_halt = (op == OP_HALT);
  // ld, ldi and st all form C(Rb) with the base-address path
  assign is_base = is_ld || is_ldi || is_st;
  assign known   = is_base || is_addi || is_alu;

  always_comb begin
    alu_code = ALU_ADD;
    if      (op == OP_SUB) alu_code = ALU_SUB;
    else if (op == OP_AND) alu_code = ALU_AND;
    else if (op == OP_OR)  alu_code = ALU_OR;
  end

  // The opcode is captured on the T2->T3 edge and held for the whole
  // execute phase, so IR may change underneath without effect.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state <= S_RST;
      op    <= 5'd0;
    end else begin
      state <= state_nx;
      if (state == S_T2) op <= IR[31:27];
    end
  end

  always_comb begin
    state_nx = state;
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0; PCin = 1'b0;
    MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; IncPc = 1'b0; Zlowin = 1'b0;
    read = 1'b0; write = 1'b0; mdr_read = 2'b00; control = ALU_ADD;
    Cout = 1'b0; BAout = 1'b0; Rin = 1'b0; Rout = 1'b0;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; halted = 1'b0; busy = 1'b0;
    case (state)
      S_RST: state_nx = S_T0;
      S_T0: begin
        // a paused sequencer keeps the datapath strobes quiet
        if (run) begin
          PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1; busy = 1'b1;
          state_nx = S_T1;
        end
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1;
        read = 1'b1; MDRin = 1'b1; mdr_read = 2'b01; busy = 1'b1;
        state_nx = mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        read = 1'b1; MDRin = 1'b1; mdr_read = 2'b01; busy = 1'b1;
        if (mem_ready) state_nx = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1; busy = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        busy = 1'b1;
        if (is_base) begin
          GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_addi || is_alu) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
        if (is_halt)    state_nx = S_HALT;
        else if (known) state_nx = S_T4;
        else            state_nx = S_T0;
      end
      S_T4: begin
        busy = 1'b1; Zlowin = 1'b1;
        if (is_alu) begin
          GRC = 1'b1; Rout = 1'b1; control = alu_code;
        end else begin
          Cout = 1'b1;
        end
        state_nx = S_T5;
      end
      S_T5: begin
        busy = 1'b1; Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin = 1'b1; state_nx = S_T6;
        end else begin
          GRA = 1'b1; Rin = 1'b1; state_nx = S_T0;
        end
      end
      S_T6: begin
        busy = 1'b1; MDRin = 1'b1;
        if (is_ld) begin
          read = 1'b1; mdr_read = 2'b01;
          if (mem_ready) state_nx = S_T7;
        end else begin
          GRA = 1'b1; Rout = 1'b1;
          state_nx = S_T7;
        end
      end
      S_T7: begin
        busy = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
          state_nx = S_T0;
        end else begin
          write = 1'b1;
          if (mem_ready) state_nx = S_T0;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_RST;
    endcase
  end

endmodule
